// File: rtl/jt49_div_seq.sv
//==============================================================================
// Module   : jt49_div_seq
// Brief    : Time-shared tone/noise period divider; one incrementer serves all
//            channels, one slot per clk after each accepted tick.
// Config   : JT49_DIV_SEQ_NOISE_EN enables the 4th (noise) slot.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module jt49_div_seq #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic         wr,
  input  logic [1:0]   addr,
  input  logic [W-1:0] din,
  output logic [3:0]   div,
  output logic         busy,
  output logic         overrun
);

`ifdef JT49_DIV_SEQ_NOISE_EN
  localparam logic [1:0] c_last_slot = 2'd3;
  localparam logic       c_noise_en  = 1'b1;
`else
  localparam logic [1:0] c_last_slot = 2'd2;
  localparam logic       c_noise_en  = 1'b0;
`endif

  localparam logic [W-1:0] c_one = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t               state_q,   state_d;
  logic [1:0]           slot_q,    slot_d;
  logic                 overrun_q, overrun_d;
  logic [3:0]           div_q,     div_d;
  logic [3:0][W-1:0]    count_q,   count_d;
  logic [3:0][W-1:0]    period_q,  period_d;
  logic [3:0][W-1:0]    shadow_q,  shadow_d;

  logic                 w_accept;
  logic                 w_hit;
  logic [W-1:0]         w_cur_cnt;
  logic [W-1:0]         w_cur_per;
  logic [W-1:0]         w_cnt_inc;

  // A tick may chain onto the sweep only while its final slot is being processed
  assign w_accept  = cen && ((state_q == ST_IDLE) || (slot_q == c_last_slot));

  // Shared datapath: one comparator and one incrementer muxed by slot
  assign w_cur_cnt = count_q[slot_q];
  assign w_cur_per = period_q[slot_q];
  assign w_hit     = (w_cur_cnt >= w_cur_per);
  assign w_cnt_inc = w_cur_cnt + c_one;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    overrun_d = overrun_q;
    div_d     = div_q;
    count_d   = count_q;
    period_d  = period_q;
    shadow_d  = shadow_q;

    if (state_q == ST_SWEEP) begin
      if (w_hit) begin
        count_d[slot_q] = c_one;
        div_d[slot_q]   = ~div_q[slot_q];
      end else begin
        count_d[slot_q] = w_cnt_inc;
      end
      slot_d = slot_q + 2'd1;
      if (slot_q == c_last_slot) begin
        state_d = ST_IDLE;
        slot_d  = 2'd0;
      end
    end

    if (w_accept) begin
      state_d  = ST_SWEEP;
      slot_d   = 2'd0;
      period_d = shadow_q;
    end else if (cen) begin
      overrun_d = 1'b1;
    end

    // Shadow update uses the pre-edge copy above, so a coincident write lands next sweep
    if (wr) begin
      if (addr == 2'd3) begin
        if (c_noise_en) begin
          shadow_d[3] = {{(W-5){1'b0}}, din[4:0]};
        end
      end else begin
        shadow_d[addr] = din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      slot_q    <= 2'd0;
      overrun_q <= 1'b0;
      div_q     <= 4'b0000;
      count_q   <= {4{c_one}};
      period_q  <= '0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      overrun_q <= overrun_d;
      div_q     <= div_d;
      count_q   <= count_d;
      period_q  <= period_d;
      shadow_q  <= shadow_d;
    end
  end

  assign div     = {div_q[3] & c_noise_en, div_q[2:0]};
  assign busy    = (state_q == ST_SWEEP);
  assign overrun = overrun_q;

endmodule

`default_nettype wire

// File: doc/jt49_div_seq.md
JT49_DIV_SEQ -- requirements
Module: jt49_div_seq

Interface
REQ-001 Parameter: W, default 12, width of tone periods and per-channel counters.
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: cen  input  1  divider tick request, one clk wide.
REQ-005 Port: wr  input  1  period write strobe.
REQ-006 Port: addr  input  2  channel select: 0=A, 1=B, 2=C, 3=noise.
REQ-007 Port: din  input  W  period value to write.
REQ-008 Port: div  output  4  square-wave outputs, bit k for channel k.
REQ-009 Port: busy  output  1  high while a sweep is in progress.
REQ-010 Port: overrun  output  1  sticky flag: a tick was dropped.

Function
REQ-011 Shall time-share one W-bit incrementer/comparator across all channels. Per-channel counters and div bits are held in registers.
REQ-012 Accepted tick:
- A cen is accepted when idle, or when the current slot is the last slot (back-to-back sweep).
- An accepted cen at edge T starts a sweep.
- Slot k is processed at edge T+1+k.
REQ-013 Slot processing for channel k:
- If count[k] >= period[k]: count[k] <= 1 and div[k] toggles.
- Else: count[k] <= count[k]+1, wrapping modulo 2^W.
REQ-014 Period 0 behaves as period 1: div toggles on every accepted tick.
REQ-015 busy rises at the edge a cen is accepted. It falls at the edge processing the last slot, unless a new cen is accepted at that same edge.
REQ-016 A cen arriving while busy and not in the last slot is dropped and sets overrun. overrun clears only on rst.
REQ-017 Writes go to a per-channel shadow register in the same cycle as wr.
REQ-018 Shadow-to-active copy:
- All shadows are copied to the active periods at the edge a cen is accepted.
- A write in that same cycle is not visible until the following sweep.
REQ-019 A write to the same channel twice between sweeps keeps the last value.
REQ-020 Noise channel period is 5 bits: din[4:0] is stored and zero-extended for comparison. Upper bits are ignored.
REQ-021 A write never alters count or div directly.

Reset
REQ-022 rst shall set:
- div=0, busy=0, overrun=0.
- all counts=1.
- all active and shadow periods=0.
- slot=0.
REQ-023 rst asserted mid-sweep shall abort the sweep. No further slot is processed; state is exactly as in REQ-022 on the next cycle.
REQ-024 cen and wr coincident with rst are ignored.

Configuration
REQ-025 Macro JT49_DIV_SEQ_NOISE_EN defined: 4 slots per sweep, channel 3 active. Minimum back-to-back cen spacing is 4 clk.
REQ-026 Macro JT49_DIV_SEQ_NOISE_EN undefined:
- 3 slots per sweep; the last slot is 2; minimum cen spacing is 3 clk.
- div[3] is tied to 0.
- Writes with addr=3 are ignored.

Verification
REQ-027 Period A=3; single cen at edge 10, all cens spaced 8 clk: div[0] toggles on every 3rd accepted tick. First toggle at the 3rd tick's slot-0 edge. busy high for edges 10..14.
REQ-028 Period B=0; ticks every 4 clk: div[1] toggles on every tick, at accepted edge +2.
REQ-029 cen at edges 20 and 22 (NOISE_EN): second cen dropped, overrun=1 from edge 22, counts advance once. cen at 20 and 24: both accepted, busy stays high continuously, overrun=0.
REQ-030 wr addr=0 din=5 in the same cycle as an accepted cen: that sweep uses the old period. The next sweep compares against 5.
REQ-031 rst pulse at edge accepted+2 during a sweep with div[0]=1: next cycle div=0, busy=0, overrun=0. A following tick sees count=1.
REQ-032 NOISE_EN undefined: wr addr=3 din=7, then 10 ticks: div[3] stays 0. busy lasts 3 edges per sweep. cen spacing 3 accepted without overrun.
